ppe_feeder: RTL and testbench
=============================

# ppe_feeder

Clocked packet source that sits directly upstream of the partial-sum PE (`ppe`) and produces the 30-bit packets it consumes. It accepts one filter row (five 8-bit weights) and then a fixed number of 25-bit input spike rows. It emits two weight packets followed by one input packet per row, all addressed to a single PE, over a valid/ready channel.

## Interface
- `PKT_W`, 30: packet width; fields [29:26] dest address, [25] opcode, [24:0] payload.
- `ADDR_W`, 4: destination address width.
- `WT_W`, 8: weight width.
- `ROWS`, 21: input rows streamed per loaded filter row (1..255).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `dest_addr`  in  ADDR_W: PE address; sampled on weight accept.
- `wt_row`  in  5*WT_W: weights w4..w0, w0 in [7:0].
- `wt_valid`  in  1 / `wt_ready`  out  1: filter-row handshake.
- `ifm_row`  in  25: input spike row.
- `ifm_valid`  in  1 / `ifm_ready`  out  1: input-row handshake.
- `pkt_data`  out  PKT_W / `pkt_valid`  out  1 / `pkt_ready`  in  1: packet channel to `ppe`.
- `done`  out  1: one-cycle pulse when the last input packet of a filter pass is taken.

## Operation
- A transfer occurs on any rising edge with valid and ready both high. Data is registered and held stable while valid is high and ready is low.
- States:
  - IDLE: waits for a filter row. `wt_ready = !pkt_valid | pkt_ready`. On accept, latches `wt_row` and `dest_addr`, loads packet W0, and moves to W1.
  - W1: when the output slot frees, loads packet W1 and moves to STREAM.
  - STREAM: `ifm_ready = !pkt_valid | pkt_ready`. Each accept loads an input packet and increments `cnt`. On the ROWS-th accept, moves to IDLE.
- Packet W0: addr=dest, opcode=0, [24]=0, [23:16]=w2, [15:8]=w1, [7:0]=w0.
- Packet W1: addr=dest, opcode=0, [24]=0, [23:16]=8'h00 (dummy, discarded by `ppe`), [15:8]=w4, [7:0]=w3.
- Input packet: addr=dest, opcode=1, [24:0]=`ifm_row` unchanged.
- `cnt` is 8-bit, cleared on weight accept, never wraps. A `last` flag travels with the final input packet. `done` asserts in the cycle after that packet's output handshake.
- `wt_ready` is low outside IDLE. `ifm_ready` is low outside STREAM. Input rows presented early are held off, not dropped.
- A new filter row is accepted in IDLE while the last input packet is still pending in the output slot only if `pkt_ready` is high in that same cycle. Otherwise it waits.
- Reset mid-pass: all state is discarded, any pending packet is dropped (`pkt_valid`=0), and the block returns to IDLE.

## Timing
- Reset values: `pkt_valid`=0, `pkt_data`=0, `wt_ready`=1 (IDLE with empty slot) in the cycle after reset deasserts, `ifm_ready`=0, `done`=0, `cnt`=0.
- Latency: accept at edge t gives `pkt_valid` high after edge t, visible in cycle t+1.
- Throughput with `pkt_ready` held high:
  - W0 in cycle t+1, W1 in t+2.
  - First input packet no earlier than t+3.
  - One packet per cycle thereafter.
- Backpressure: with `pkt_ready` low, `pkt_data` is frozen and both input readies are low. No bubble is inserted when ready returns.
- `done` is high for exactly one cycle per pass.

## Structure
- Shared package `ppe_pkt_pkg`:
  - constants ADDR_HI=29, ADDR_LO=26, OPCODE_BIT=25, OP_WEIGHT=1'b0, OP_INPUT=1'b1;
  - `typedef logic [29:0] ppe_pkt_t`;
  - packing functions `mk_wt_pkt` and `mk_in_pkt`.
  The `ppe` testbench and other producers reuse this package.
- One sub-module, `pkt_out_slot`: a one-entry valid/ready register holding data plus `last`. It exposes `slot_free = !valid | ready`.
- FSM, counter and weight latch stay in `ppe_feeder`.

## Test plan
- Reset, then `wt_row`={4,5,3,2,1}, dest=5, `pkt_ready`=1 → W0=0x14030201 (addr 5, op 0, 3/2/1); W1 next cycle with [15:8]=4, [7:0]=5, [23:16]=0.
- After weights, `ifm_row`=25'h1FFFFFF with ROWS=1 → one packet with [29:26]=5, [25]=1, [24:0]=all ones; `done` pulses one cycle after the handshake; `wt_ready` is 1 again.
- ROWS=3 with `ifm_valid` held high and `ifm_row` = 1, 2, 3 in order → three back-to-back input packets with those payloads; the fourth row is not accepted (`ifm_ready`=0).
- `pkt_ready` held low for 5 cycles during W0 → `pkt_data` stable; `wt_ready`/`ifm_ready` low; W1 appears in the cycle after release.
- `ifm_valid`=1 before any weights → `ifm_ready` stays 0 and no packet is emitted until W0 and W1 have been sent.
- `rst` asserted while the 2nd of 3 rows is pending → `pkt_valid`=0 next cycle; a fresh pass then starts with W0 and `cnt` restarts at 0.

Source files
------------

// File: rtl/ppe_pkt_pkg.sv
// Packet format shared by the ppe partial-sum PE and everything that feeds it.
// Pure types, constants and packing helpers; no timing of its own.
// Not applicable: holds no state and applies no flow control.
package ppe_pkt_pkg;

  localparam int PKT_W     = 30;
  localparam int ADDR_W    = 4;
  localparam int WT_W      = 8;
  localparam int PAYLOAD_W = 25;

  localparam int ADDR_HI    = 29;
  localparam int ADDR_LO    = 26;
  localparam int OPCODE_BIT = 25;

  localparam logic OP_WEIGHT = 1'b0;
  localparam logic OP_INPUT  = 1'b1;

  typedef logic [29:0] ppe_pkt_t;

  // Feeder sequencing: wait for weights, send the second weight packet, stream rows.
  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_W1     = 2'd1,
    FS_STREAM = 2'd2
  } feeder_state_t;

  // Weight packet: three 8-bit weights in the low 24 bits, bit 24 always zero.
  function automatic ppe_pkt_t mk_wt_pkt(input logic [3:0] addr,
                                         input logic [7:0] hi,
                                         input logic [7:0] mid,
                                         input logic [7:0] lo);
    ppe_pkt_t p;
    p                   = '0;
    p[ADDR_HI:ADDR_LO]  = addr;
    p[OPCODE_BIT]       = OP_WEIGHT;
    p[24]               = 1'b0;
    p[23:16]            = hi;
    p[15:8]             = mid;
    p[7:0]              = lo;
    return p;
  endfunction

  // Input packet: the 25-bit spike row is carried unchanged.
  function automatic ppe_pkt_t mk_in_pkt(input logic [3:0]  addr,
                                         input logic [24:0] row);
    ppe_pkt_t p;
    p                  = '0;
    p[ADDR_HI:ADDR_LO] = addr;
    p[OPCODE_BIT]      = OP_INPUT;
    p[24:0]            = row;
    return p;
  endfunction

endpackage

// File: rtl/pkt_out_slot.sv
// One-entry output register carrying a packet plus its end-of-pass marker.
// Latency: a load at edge t is visible as valid data in cycle t+1.
// Backpressure: data holds while valid && !ready; slot_free lets a reload overlap the drain.
module pkt_out_slot #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last,
  output logic         slot_free
);

  // The slot can take new data when it is empty or being drained this cycle.
  assign slot_free = !valid || ready;

  // Hold register: a load wins over a drain so back-to-back packets leave no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/ppe_feeder.sv
// Packet source for one ppe: two weight packets per filter row, then ROWS input packets.
// Latency: accept at edge t gives a packet in cycle t+1; one packet per cycle when drained.
// Backpressure: both input readies drop while the output slot is full and stalled.
module ppe_feeder
  import ppe_pkt_pkg::*;
#(
  parameter int PKT_W  = 30,
  parameter int ADDR_W = 4,
  parameter int WT_W   = 8,
  parameter int ROWS   = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [5*WT_W-1:0] wt_row,
  input  logic              wt_valid,
  output logic              wt_ready,
  input  logic [24:0]       ifm_row,
  input  logic              ifm_valid,
  output logic              ifm_ready,
  output logic [PKT_W-1:0]  pkt_data,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic              done
);

  localparam logic [7:0] ROWS_M1 = 8'(ROWS - 1);

  feeder_state_t state, state_nxt;

  logic [ADDR_W-1:0] dest_q;
  logic [2*WT_W-1:0] wt_hi_q;   // w4,w3: only these are needed after W0 is built
  logic [7:0]        cnt;

  logic        slot_free;
  logic        slot_last;
  logic        load;
  ppe_pkt_t    load_data;
  logic        load_last;
  logic        row_last;
  logic        wt_take;
  logic        ifm_take;

  assign row_last = (cnt == ROWS_M1);
  assign wt_take  = wt_valid && wt_ready;
  assign ifm_take = ifm_valid && ifm_ready;

  // Next-state and slot-load decode; readies only open in their own state.
  always_comb begin
    state_nxt = state;
    wt_ready  = 1'b0;
    ifm_ready = 1'b0;
    load      = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    case (state)
      FS_IDLE: begin
        wt_ready = slot_free;
        if (wt_valid && slot_free) begin
          load      = 1'b1;
          load_data = mk_wt_pkt(dest_addr, wt_row[3*WT_W-1:2*WT_W],
                                wt_row[2*WT_W-1:WT_W], wt_row[WT_W-1:0]);
          state_nxt = FS_W1;
        end
      end
      FS_W1: begin
        if (slot_free) begin
          // Upper weight byte is a dummy zero the PE discards.
          load      = 1'b1;
          load_data = mk_wt_pkt(dest_q, 8'h00, wt_hi_q[2*WT_W-1:WT_W],
                                wt_hi_q[WT_W-1:0]);
          state_nxt = FS_STREAM;
        end
      end
      FS_STREAM: begin
        ifm_ready = slot_free;
        if (ifm_valid && slot_free) begin
          load      = 1'b1;
          load_data = mk_in_pkt(dest_q, ifm_row);
          load_last = row_last;
          if (row_last) begin
            state_nxt = FS_IDLE;
          end
        end
      end
      default: state_nxt = FS_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture destination and the weights still owed to the W1 packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q  <= '0;
      wt_hi_q <= '0;
    end else if (wt_take) begin
      dest_q  <= dest_addr;
      wt_hi_q <= wt_row[5*WT_W-1:3*WT_W];
    end
  end

  // Row counter: restarts on each filter row, saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (wt_take) begin
      cnt <= 8'd0;
    end else if (ifm_take && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Pulse once, the cycle after the final input packet leaves the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= pkt_valid && pkt_ready && slot_last;
    end
  end

  pkt_out_slot #(.W(PKT_W)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .ready     (pkt_ready),
    .valid     (pkt_valid),
    .data      (pkt_data),
    .last      (slot_last),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_ppe_feeder.sv
// Directed checks of ppe_feeder followed by a randomized run against a packet-queue model.
module tb_ppe_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dest_addr;
  logic [39:0] wt_row;
  logic        wt_valid;
  logic [24:0] ifm_row;
  logic        ifm_valid;
  logic        pkt_ready;

  logic        wt_ready, ifm_ready, pkt_valid, done;
  logic [29:0] pkt_data;
  logic        wt_ready1, ifm_ready1, pkt_valid1, done1;
  logic [29:0] pkt_data1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ppe_feeder #(.ROWS(3)) dut (
    .clk(clk), .rst(rst), .dest_addr(dest_addr), .wt_row(wt_row),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .ifm_row(ifm_row),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .pkt_data(pkt_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .done(done)
  );

  ppe_feeder #(.ROWS(1)) dut1 (
    .clk(clk), .rst(rst), .dest_addr(dest_addr), .wt_row(wt_row),
    .wt_valid(wt_valid), .wt_ready(wt_ready1), .ifm_row(ifm_row),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready1), .pkt_data(pkt_data1),
    .pkt_valid(pkt_valid1), .pkt_ready(pkt_ready), .done(done1)
  );

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference packet images built straight from the field layout.
  function automatic logic [29:0] w0_pkt(input logic [3:0] a, input logic [39:0] w);
    return {a, 1'b0, 1'b0, w[23:16], w[15:8], w[7:0]};
  endfunction
  function automatic logic [29:0] w1_pkt(input logic [3:0] a, input logic [39:0] w);
    return {a, 1'b0, 1'b0, 8'h00, w[39:32], w[31:24]};
  endfunction
  function automatic logic [29:0] in_pkt(input logic [3:0] a, input logic [24:0] r);
    return {a, 1'b1, r};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    wt_valid  = 1'b0;
    ifm_valid = 1'b0;
    pkt_ready = 1'b1;
    dest_addr = 4'd0;
    wt_row    = '0;
    ifm_row   = '0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Model state for the random phase.
  logic [30:0] q[$];
  logic [30:0] e;
  logic        pass_active;
  int          rows_got;
  int          passes;
  logic        exp_done;
  logic        prev_hold;
  logic [29:0] prev_data;
  logic [3:0]  m_dest;
  logic [39:0] m_w;
  logic [39:0] rw;
  logic        lst;

  initial begin
    // ---------------- reset state
    do_reset();
    chk_b("rst_pkt_valid", pkt_valid, 1'b0);
    chk_d("rst_pkt_data", pkt_data, 30'd0);
    chk_b("rst_wt_ready", wt_ready, 1'b1);
    chk_b("rst_ifm_ready", ifm_ready, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_d("rst_cnt", {22'd0, dut.cnt}, 30'd0);

    // ---------------- ROWS=1: weights {4,5,3,2,1} to PE 5, one all-ones row
    wt_valid  = 1'b1;
    wt_row    = {8'd4, 8'd5, 8'd3, 8'd2, 8'd1};
    dest_addr = 4'd5;
    #1 chk_b("r1_wt_ready", wt_ready1, 1'b1);
    step(); wt_valid = 1'b0;
    #1 chk_b("r1_w0_valid", pkt_valid1, 1'b1);
    chk_d("r1_w0", pkt_data1, 30'h14030201);
    step(); ifm_valid = 1'b1; ifm_row = 25'h1FFFFFF;
    #1 chk_d("r1_w1", pkt_data1, 30'h14000405);
    chk_b("r1_ifm_ready", ifm_ready1, 1'b1);
    step(); ifm_valid = 1'b0;
    #1 chk_d("r1_in", pkt_data1, 30'h17FFFFFF);
    chk_b("r1_done_early", done1, 1'b0);
    step();
    #1 chk_b("r1_done", done1, 1'b1);
    chk_b("r1_wt_ready_again", wt_ready1, 1'b1);
    chk_b("r1_empty", pkt_valid1, 1'b0);
    step();
    #1 chk_b("r1_done_one_cycle", done1, 1'b0);

    // ---------------- ROWS=3: rows held early, then back-to-back 1,2,3
    do_reset();
    rw = {8'($urandom), 32'($urandom)};
    wt_valid = 1'b1; wt_row = rw; dest_addr = 4'hA;
    ifm_valid = 1'b1; ifm_row = 25'd1;
    #1 chk_b("early_ifm_ready_idle", ifm_ready, 1'b0);
    chk_b("early_no_pkt", pkt_valid, 1'b0);
    step(); wt_valid = 1'b0;
    #1 chk_d("r3_w0", pkt_data, w0_pkt(4'hA, rw));
    chk_b("early_ifm_ready_w1", ifm_ready, 1'b0);
    step();
    #1 chk_d("r3_w1", pkt_data, w1_pkt(4'hA, rw));
    chk_b("r3_ifm_ready", ifm_ready, 1'b1);
    step(); ifm_row = 25'd2;
    #1 chk_d("r3_in1", pkt_data, in_pkt(4'hA, 25'd1));
    step(); ifm_row = 25'd3;
    #1 chk_d("r3_in2", pkt_data, in_pkt(4'hA, 25'd2));
    step(); ifm_row = 25'd4;
    #1 chk_d("r3_in3", pkt_data, in_pkt(4'hA, 25'd3));
    chk_b("r3_fourth_held", ifm_ready, 1'b0);
    chk_d("r3_cnt", {22'd0, dut.cnt}, 30'd3);
    step(); ifm_valid = 1'b0;
    #1 chk_b("r3_done", done, 1'b1);
    chk_b("r3_no_fourth", pkt_valid, 1'b0);

    // ---------------- backpressure on W0 for 5 cycles
    do_reset();
    rw = {8'($urandom), 32'($urandom)};
    wt_valid = 1'b1; wt_row = rw; dest_addr = 4'h3; ifm_valid = 1'b1;
    step(); wt_valid = 1'b0; pkt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk_d("bp_w0_frozen", pkt_data, w0_pkt(4'h3, rw));
      chk_b("bp_w0_valid", pkt_valid, 1'b1);
      chk_b("bp_wt_ready", wt_ready, 1'b0);
      chk_b("bp_ifm_ready", ifm_ready, 1'b0);
      step();
    end
    pkt_ready = 1'b1;
    #1 chk_d("bp_w0_release", pkt_data, w0_pkt(4'h3, rw));
    step();
    #1 chk_d("bp_w1_after", pkt_data, w1_pkt(4'h3, rw));

    // ---------------- reset while the 2nd of 3 rows is pending
    do_reset();
    rw = {8'($urandom), 32'($urandom)};
    wt_valid = 1'b1; wt_row = rw; dest_addr = 4'h7;
    ifm_valid = 1'b1; ifm_row = 25'd11;
    step(); wt_valid = 1'b0;
    step();
    step(); ifm_row = 25'd22;
    step(); ifm_valid = 1'b0; pkt_ready = 1'b0;
    #1 chk_d("mid_row2_pending", pkt_data, in_pkt(4'h7, 25'd22));
    rst = 1'b1;
    step(); rst = 1'b0;
    #1 chk_b("mid_dropped", pkt_valid, 1'b0);
    chk_d("mid_cnt_cleared", {22'd0, dut.cnt}, 30'd0);
    rw = {8'($urandom), 32'($urandom)};
    wt_valid = 1'b1; wt_row = rw; dest_addr = 4'h9; pkt_ready = 1'b1;
    #1 chk_b("mid_wt_ready", wt_ready, 1'b1);
    step(); wt_valid = 1'b0;
    #1 chk_d("mid_fresh_w0", pkt_data, w0_pkt(4'h9, rw));
    chk_d("mid_cnt_restart", {22'd0, dut.cnt}, 30'd0);

    // ---------------- randomized traffic against the queue model (ROWS=3)
    do_reset();
    q.delete();
    pass_active = 1'b0;
    rows_got    = 0;
    passes      = 0;
    exp_done    = 1'b0;
    prev_hold   = 1'b0;
    prev_data   = '0;
    m_dest      = '0;
    m_w         = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      wt_row    = {8'($urandom), 32'($urandom)};
      dest_addr = 4'($urandom);
      ifm_row   = 25'($urandom);
      if (cyc < 2980) begin
        wt_valid  = ($urandom_range(0, 3) == 0);
        ifm_valid = ($urandom_range(0, 1) == 0);
        pkt_ready = ($urandom_range(0, 3) != 0);
      end else begin
        wt_valid  = 1'b0;
        ifm_valid = 1'b0;
        pkt_ready = 1'b1;
      end
      #1;
      chk_b("rnd_done", done, exp_done);
      if (prev_hold) begin
        chk_b("rnd_hold_valid", pkt_valid, 1'b1);
        chk_d("rnd_hold_data", pkt_data, prev_data);
      end
      if (pkt_valid && !pkt_ready) begin
        chk_b("rnd_bp_wt_ready", wt_ready, 1'b0);
        chk_b("rnd_bp_ifm_ready", ifm_ready, 1'b0);
      end
      exp_done = 1'b0;
      if (pkt_valid && pkt_ready) begin
        chk_b("rnd_pkt_expected", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk_d("rnd_pkt_data", pkt_data, e[29:0]);
          exp_done = e[30];
          if (e[30]) passes++;
        end
      end
      if (wt_valid && wt_ready) begin
        chk_b("rnd_wt_between_passes", pass_active, 1'b0);
        m_dest = dest_addr;
        m_w    = wt_row;
        q.push_back({1'b0, w0_pkt(m_dest, m_w)});
        q.push_back({1'b0, w1_pkt(m_dest, m_w)});
        pass_active = 1'b1;
        rows_got    = 0;
      end
      if (ifm_valid && ifm_ready) begin
        chk_b("rnd_ifm_in_pass", pass_active, 1'b1);
        rows_got++;
        lst = (rows_got == 3);
        q.push_back({lst, in_pkt(m_dest, ifm_row)});
        if (lst) pass_active = 1'b0;
      end
      prev_hold = pkt_valid && !pkt_ready;
      prev_data = pkt_data;
    end
    chk_b("rnd_queue_drained", q.size() == 0, 1'b1);
    chk_b("rnd_enough_passes", passes >= 20, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
